// File: rtl/mcycle_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mcycle_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned FN_W  = 5;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
  localparam logic [OP_W-1:0] FN_SRA  = 6'h03;
  localparam logic [OP_W-1:0] FN_JR   = 6'h08;
  localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [OP_W-1:0] FN_SLTU = 6'h2B;

  localparam logic [FN_W-1:0] ALU_ADD  = 5'b00001;
  localparam logic [FN_W-1:0] ALU_SUB  = 5'b10001;
  localparam logic [FN_W-1:0] ALU_SLT  = 5'b10011;
  localparam logic [FN_W-1:0] ALU_SLTU = 5'b10111;
  localparam logic [FN_W-1:0] ALU_AND  = 5'b00000;
  localparam logic [FN_W-1:0] ALU_OR   = 5'b00100;
  localparam logic [FN_W-1:0] ALU_XOR  = 5'b01000;
  localparam logic [FN_W-1:0] ALU_NOR  = 5'b01100;
  localparam logic [FN_W-1:0] ALU_SLL  = 5'b00010;
  localparam logic [FN_W-1:0] ALU_SRL  = 5'b01010;
  localparam logic [FN_W-1:0] ALU_SRA  = 5'b01110;

  localparam logic [SEL_W-1:0] PC_PC4 = 2'b00;
  localparam logic [SEL_W-1:0] PC_BR  = 2'b01;
  localparam logic [SEL_W-1:0] PC_JMP = 2'b10;
  localparam logic [SEL_W-1:0] PC_JR  = 2'b11;
  localparam logic [SEL_W-1:0] WA_RD  = 2'b00;
  localparam logic [SEL_W-1:0] WA_RT  = 2'b01;
  localparam logic [SEL_W-1:0] WA_R31 = 2'b10;
  localparam logic [SEL_W-1:0] WD_PC4 = 2'b00;
  localparam logic [SEL_W-1:0] WD_ALU = 2'b01;
  localparam logic [SEL_W-1:0] WD_MEM = 2'b10;
  localparam logic [SEL_W-1:0] AS_RS    = 2'b00;
  localparam logic [SEL_W-1:0] AS_SHAMT = 2'b01;
  localparam logic [SEL_W-1:0] AS_C16   = 2'b10;

  typedef struct packed {
    logic [SEL_W-1:0] pcsel;
    logic [SEL_W-1:0] wasel;
    logic [SEL_W-1:0] wdsel;
    logic [SEL_W-1:0] asel;
    logic [FN_W-1:0]  alufn;
    logic             sgnext;
    logic             bsel;
    logic             is_mem;
    logic             is_store;
    logic             writes;
    logic             illegal;
  } ctrl_t;

endpackage

// File: rtl/mcycle_decode.sv
// Pure combinational instruction decoder: opcode/funct (and Z for branches)
// to datapath selects, ALU function and instruction class flags.
module mcycle_decode
  import mcycle_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] funct,
  input  logic            z,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.wasel  = WA_RD;
        ctrl.wdsel  = WD_ALU;
        ctrl.writes = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alufn = ALU_ADD;
          FN_SUB:  ctrl.alufn = ALU_SUB;
          FN_AND:  ctrl.alufn = ALU_AND;
          FN_OR:   ctrl.alufn = ALU_OR;
          FN_XOR:  ctrl.alufn = ALU_XOR;
          FN_NOR:  ctrl.alufn = ALU_NOR;
          FN_SLT:  ctrl.alufn = ALU_SLT;
          FN_SLTU: ctrl.alufn = ALU_SLTU;
          FN_SLL: begin
            ctrl.alufn = ALU_SLL;
            ctrl.asel  = AS_SHAMT;
          end
          FN_SRL: begin
            ctrl.alufn = ALU_SRL;
            ctrl.asel  = AS_SHAMT;
          end
          FN_SRA: begin
            ctrl.alufn = ALU_SRA;
            ctrl.asel  = AS_SHAMT;
          end
          FN_JR: begin
            ctrl.pcsel  = PC_JR;
            ctrl.wdsel  = WD_PC4;
            ctrl.writes = 1'b0;
          end
          default: begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.wasel  = WA_RT;
        ctrl.wdsel  = WD_ALU;
        ctrl.bsel   = 1'b1;
        ctrl.sgnext = 1'b1;
        ctrl.writes = 1'b1;
        case (op)
          OP_SLTI:  ctrl.alufn = ALU_SLT;
          OP_SLTIU: ctrl.alufn = ALU_SLTU;
          OP_ANDI: begin
            ctrl.alufn  = ALU_AND;
            ctrl.sgnext = 1'b0;
          end
          OP_ORI: begin
            ctrl.alufn  = ALU_OR;
            ctrl.sgnext = 1'b0;
          end
          OP_XORI: begin
            ctrl.alufn  = ALU_XOR;
            ctrl.sgnext = 1'b0;
          end
          // lui: immediate shifted left by the constant 16 on the A side
          OP_LUI: begin
            ctrl.alufn = ALU_SLL;
            ctrl.asel  = AS_C16;
          end
          default: ctrl.alufn = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ctrl.wasel  = WA_RT;
        ctrl.wdsel  = WD_MEM;
        ctrl.bsel   = 1'b1;
        ctrl.sgnext = 1'b1;
        ctrl.alufn  = ALU_ADD;
        ctrl.is_mem = 1'b1;
        ctrl.writes = 1'b1;
      end
      OP_SW: begin
        ctrl.bsel     = 1'b1;
        ctrl.sgnext   = 1'b1;
        ctrl.alufn    = ALU_ADD;
        ctrl.is_mem   = 1'b1;
        ctrl.is_store = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alufn  = ALU_SUB;
        ctrl.sgnext = 1'b1;
        ctrl.pcsel  = z ? PC_BR : PC_PC4;
      end
      OP_BNE: begin
        ctrl.alufn  = ALU_SUB;
        ctrl.sgnext = 1'b1;
        ctrl.pcsel  = z ? PC_PC4 : PC_BR;
      end
      OP_J: ctrl.pcsel = PC_JMP;
      OP_JAL: begin
        ctrl.pcsel  = PC_JMP;
        ctrl.wasel  = WA_R31;
        ctrl.wdsel  = WD_PC4;
        ctrl.writes = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH -> EXEC -> (MEM) -> FETCH, with a
// memory-wait watchdog and an absorbing HALT for illegal code or timeout.
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int unsigned Dbits    = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Dbits-1:0] imem_rdata,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             Z,
  output logic [Dbits-1:0] instr,
  output logic [1:0]       pcsel,
  output logic [1:0]       wasel,
  output logic [1:0]       wdsel,
  output logic [1:0]       asel,
  output logic             sgnext,
  output logic             bsel,
  output logic             werf,
  output logic [4:0]       alufn,
  output logic             enable,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             halted,
  output logic             timeout
);

  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  state_t           state, state_nxt;
  logic [Dbits-1:0] ir_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             timeout_nxt;
  logic             wait_hit;
  ctrl_t            dec;

  mcycle_decode u_decode (
    .op    (instr[31:26]),
    .funct (instr[5:0]),
    .z     (Z),
    .ctrl  (dec)
  );

  assign cnt_inc  = cnt + CNT_W'(1);
  assign wait_hit = (cnt_inc == CNT_W'(WAIT_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_FETCH;
      instr   <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      instr   <= ir_nxt;
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
    end
  end

  // Sequencing plus the ack-wait counter shared by FETCH and MEM
  always_comb begin
    state_nxt   = state;
    ir_nxt      = instr;
    cnt_nxt     = cnt;
    timeout_nxt = timeout;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          ir_nxt    = imem_rdata;
          cnt_nxt   = '0;
          state_nxt = S_EXEC;
        end else if (wait_hit) begin
          state_nxt   = S_HALT;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_EXEC: begin
        cnt_nxt = '0;
        if (dec.illegal)     state_nxt = S_HALT;
        else if (dec.is_mem) state_nxt = S_MEM;
        else                 state_nxt = S_FETCH;
      end
      S_MEM: begin
        if (dmem_ack) begin
          cnt_nxt   = '0;
          state_nxt = S_FETCH;
        end else if (wait_hit) begin
          state_nxt   = S_HALT;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_HALT: state_nxt = S_HALT;
    endcase
  end

  always_comb begin
    pcsel    = '0;
    wasel    = '0;
    wdsel    = '0;
    asel     = '0;
    alufn    = '0;
    sgnext   = 1'b0;
    bsel     = 1'b0;
    werf     = 1'b0;
    enable   = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        if (!dec.illegal) begin
          pcsel  = dec.pcsel;
          wasel  = dec.wasel;
          wdsel  = dec.is_mem ? WD_PC4 : dec.wdsel;
          asel   = dec.asel;
          alufn  = dec.alufn;
          sgnext = dec.sgnext;
          bsel   = dec.bsel;
          enable = !dec.is_mem;
          werf   = dec.writes && !dec.is_mem;
        end
      end
      // Address selects held for the whole access; writeback only on ack
      S_MEM: begin
        wasel    = dec.wasel;
        asel     = dec.asel;
        alufn    = dec.alufn;
        sgnext   = dec.sgnext;
        bsel     = dec.bsel;
        dmem_req = 1'b1;
        dmem_we  = dec.is_store;
        if (dmem_ack) begin
          enable = 1'b1;
          werf   = dec.writes;
          wdsel  = dec.wdsel;
        end
      end
      S_HALT: halted = 1'b1;
    endcase
    // No strobe leaves the block while reset is being applied
    if (!reset) begin
      werf     = 1'b0;
      enable   = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Scoreboard bench for mcycle_ctrl: directed instruction stream with
// hand-computed control snapshots compared at retire/halt/reset-release.
module tb_mcycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        z = 1'b0;
  logic [31:0] instr;
  logic [1:0]  pcsel, wasel, wdsel, asel;
  logic        sgnext, bsel, werf, enable, imem_req, dmem_req, dmem_we;
  logic        halted, timeout;
  logic [4:0]  alufn;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  pcsel;
    logic [1:0]  wasel;
    logic [1:0]  wdsel;
    logic [1:0]  asel;
    logic [4:0]  alufn;
    logic        sgnext;
    logic        bsel;
    logic        werf;
    logic        enable;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        halted;
    logic        timeout;
    logic [7:0]  lat;
  } snap_t;

  typedef struct {
    string name;
    snap_t s;
  } exp_t;

  exp_t exp_q[$];

  mcycle_ctrl #(.Dbits(32), .WAIT_MAX(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .Z          (z),
    .instr      (instr),
    .pcsel      (pcsel),
    .wasel      (wasel),
    .wdsel      (wdsel),
    .asel       (asel),
    .sgnext     (sgnext),
    .bsel       (bsel),
    .werf       (werf),
    .alufn      (alufn),
    .enable     (enable),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .halted     (halted),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(logic [31:0] i, logic [1:0] pc, logic [1:0] wa,
                               logic [1:0] wd, logic [1:0] as, logic [4:0] fn,
                               logic sx, logic bs, logic wr, logic en, logic irq,
                               logic drq, logic dw, logic hl, logic to, logic [7:0] lat);
    snap_t s;
    s = {i, pc, wa, wd, as, fn, sx, bs, wr, en, irq, drq, dw, hl, to, lat};
    return s;
  endfunction

  // Snapshot for a non-memory instruction retiring in EXEC
  function automatic snap_t rt(logic [31:0] i, logic [1:0] pc, logic [1:0] wa,
                               logic [1:0] wd, logic [1:0] as, logic [4:0] fn,
                               logic sx, logic bs, logic wr);
    return mk(i, pc, wa, wd, as, fn, sx, bs, wr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("ir=%h pc=%b wa=%b wd=%b as=%b fn=%b sx=%b bs=%b wr=%b en=%b ireq=%b dreq=%b we=%b hlt=%b to=%b lat=%0d",
                     s.instr, s.pcsel, s.wasel, s.wdsel, s.asel, s.alufn, s.sgnext, s.bsel,
                     s.werf, s.enable, s.imem_req, s.dmem_req, s.dmem_we, s.halted, s.timeout, s.lat);
  endfunction

  task automatic push(input string name, input snap_t s);
    exp_t e;
    e.name = name;
    e.s    = s;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch with fw wait cycles, one EXEC cycle, then mw MEM cycles (ack on last)
  task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input logic zv);
    imem_rdata = w;
    z = zv;
    repeat (fw) begin
      imem_ack = 1'b0;
      step();
    end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    if (mw > 0) begin
      repeat (mw - 1) begin
        dmem_ack = 1'b0;
        step();
      end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
    end
  endtask

  snap_t rst_snap;

  // Monitor: per-cycle invariants plus scoreboard pops on observable events
  initial begin : monitor
    logic  prev_rst;
    logic  halted_prev;
    int    since;
    snap_t a;
    exp_t  e;
    prev_rst    = 1'b0;
    halted_prev = 1'b0;
    since       = 0;
    forever begin
      @(negedge clk);
      if (!reset) since = 0;
      else        since = since + 1;
      if (reset) begin
        tests++;
        if ((werf && !enable) || (wdsel == 2'b10 && !enable)) begin
          fails++;
          $display("FAIL strobe_gate: got werf=%b wdsel=%b enable=%b, required werf/wdsel=10 only with enable",
                   werf, wdsel, enable);
        end
        if (halted) begin
          tests++;
          if (enable || werf || imem_req || dmem_req || dmem_we) begin
            fails++;
            $display("FAIL halt_quiet: got en=%b werf=%b ireq=%b dreq=%b we=%b, required all 0",
                     enable, werf, imem_req, dmem_req, dmem_we);
          end
        end
        if (prev_rst && halted_prev) begin
          tests++;
          if (!halted) begin
            fails++;
            $display("FAIL halt_absorb: got halted=%b, required 1", halted);
          end
        end
        if (!prev_rst || enable || (halted && !halted_prev)) begin
          a = {instr, pcsel, wasel, wdsel, asel, alufn, sgnext, bsel, werf, enable,
               imem_req, dmem_req, dmem_we, halted, timeout, 8'(since)};
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got %s, required no event", fmt(a));
          end else begin
            e = exp_q.pop_front();
            if (a !== e.s) begin
              fails++;
              $display("FAIL %s: got %s", e.name, fmt(a));
              $display("FAIL %s: required %s", e.name, fmt(e.s));
            end
          end
        end
        if (imem_req && imem_ack) since = 0;
      end
      prev_rst    = reset;
      halted_prev = halted;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish by 100000, required end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_snap = mk(32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    reset = 1'b0;
    repeat (3) step();
    push("reset_init", rst_snap);
    reset = 1'b1;

    push("addi", rt(32'h20080005, 2'b00, 2'b01, 2'b01, 2'b00, 5'b00001, 1'b1, 1'b1, 1'b1));
    run_instr(32'h20080005, 2, 0, 1'b0);
    push("lw", mk(32'h8D090004, 2'b00, 2'b01, 2'b10, 2'b00, 5'b00001, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4));
    run_instr(32'h8D090004, 0, 3, 1'b0);
    push("beq_z1", rt(32'h11090003, 2'b01, 2'b00, 2'b00, 2'b00, 5'b10001, 1'b1, 1'b0, 1'b0));
    run_instr(32'h11090003, 0, 0, 1'b1);
    push("beq_z0", rt(32'h11090003, 2'b00, 2'b00, 2'b00, 2'b00, 5'b10001, 1'b1, 1'b0, 1'b0));
    run_instr(32'h11090003, 1, 0, 1'b0);
    push("bne_z0", rt(32'h15090003, 2'b01, 2'b00, 2'b00, 2'b00, 5'b10001, 1'b1, 1'b0, 1'b0));
    run_instr(32'h15090003, 0, 0, 1'b0);
    push("sw", mk(32'hAD090004, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00001, 1'b1, 1'b1, 1'b0,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2));
    run_instr(32'hAD090004, 0, 1, 1'b0);
    push("add", rt(32'h012A4020, 2'b00, 2'b00, 2'b01, 2'b00, 5'b00001, 1'b0, 1'b0, 1'b1));
    run_instr(32'h012A4020, 0, 0, 1'b0);
    push("slt", rt(32'h012A402A, 2'b00, 2'b00, 2'b01, 2'b00, 5'b10011, 1'b0, 1'b0, 1'b1));
    run_instr(32'h012A402A, 0, 0, 1'b0);
    push("sll", rt(32'h00094100, 2'b00, 2'b00, 2'b01, 2'b01, 5'b00010, 1'b0, 1'b0, 1'b1));
    run_instr(32'h00094100, 0, 0, 1'b0);
    push("lui", rt(32'h3C081234, 2'b00, 2'b01, 2'b01, 2'b10, 5'b00010, 1'b1, 1'b1, 1'b1));
    run_instr(32'h3C081234, 0, 0, 1'b0);
    push("ori", rt(32'h352800FF, 2'b00, 2'b01, 2'b01, 2'b00, 5'b00100, 1'b0, 1'b1, 1'b1));
    run_instr(32'h352800FF, 0, 0, 1'b0);
    push("jal", rt(32'h0C000010, 2'b10, 2'b10, 2'b00, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b1));
    run_instr(32'h0C000010, 0, 0, 1'b0);
    push("jr", rt(32'h03E00008, 2'b11, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0));
    run_instr(32'h03E00008, 0, 0, 1'b0);

    // Illegal opcode: halt, then acks must be ignored until reset
    push("illegal_halt", mk(32'hFC000000, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2));
    run_instr(32'hFC000000, 0, 0, 1'b0);
    imem_rdata = 32'h20080005;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (5) step();
    reset = 1'b0;
    repeat (2) step();
    push("reset_after_halt", rst_snap);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    reset = 1'b1;

    // Fetch ack withheld: watchdog halt after 15 waiting cycles
    push("timeout_halt", mk(32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd16));
    repeat (20) step();
    reset = 1'b0;
    step();
    push("reset_after_timeout", rst_snap);
    reset = 1'b1;

    // Reset in the middle of a store's MEM phase with an ack pending
    imem_rdata = 32'hAD090004;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    dmem_ack = 1'b0;
    step();
    reset = 1'b0;
    dmem_ack = 1'b1;
    step();
    push("reset_mid_mem", rst_snap);
    reset = 1'b1;
    imem_ack = 1'b0;
    step();
    dmem_ack = 1'b0;

    push("addi_after_reset", rt(32'h20080005, 2'b00, 2'b01, 2'b01, 2'b00, 5'b00001, 1'b1, 1'b1, 1'b1));
    run_instr(32'h20080005, 0, 0, 1'b0);
    repeat (3) step();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending events, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
